data_mem_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the single-port data memory (`MemoryData`). It shares the memory's one address/write port between the core load/store unit (port 0) and the program/debug loader (port 1). Each access completes with a request/acknowledge handshake and registered read data. The block sits between the requesters and the memory instance and is the only driver of the memory's `endr`, `We` and `din` inputs.

---
 rtl/data_mem_arb_pkg.sv | 20 ++
 rtl/data_mem_arbiter_arb2_select.sv | 36 +++
 rtl/data_mem_arbiter.sv | 128 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the data memory arbiter.
// Optional round-robin selection is enabled by defining DATA_MEM_ARB_RR_EN.
package data_mem_arb_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_ACK  = 1'b1;

    localparam logic PORT_CORE   = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

    // Port 0 wins the first contention after reset
    localparam logic LAST_GNT_RST = PORT_LOADER;

    function automatic logic gnt_to_port(input logic [1:0] gnt);
        return (gnt == 2'b10) ? PORT_LOADER : PORT_CORE;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_arb2_select.sv
// Two-requester winner selection producing a one-hot grant.
// DATA_MEM_ARB_RR_EN selects round-robin; otherwise port 0 has fixed priority.
module arb2_select
    import data_mem_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

`ifdef DATA_MEM_ARB_RR_EN
    always_comb begin
        gnt = 2'b00;
        if (req0 && req1) begin
            // On contention the port that did not win last time goes next
            gnt = (last_gnt == PORT_CORE) ? 2'b10 : 2'b01;
        end else begin
            gnt = {req1, req0};
        end
    end
`else
    logic w_unused_last_gnt;
    assign w_unused_last_gnt = last_gnt;

    always_comb begin
        gnt = 2'b00;
        if (req0) begin
            gnt = 2'b01;
        end else if (req1) begin
            gnt = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbiter and access sequencer sharing the single-port data memory between
// the load/store unit (port 0) and the loader (port 1). See DATA_MEM_ARB_RR_EN.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int unsigned BITS = 64,
    parameter int unsigned AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0,
    input  logic            we0,
    input  logic [AW-1:0]   addr0,
    input  logic [BITS-1:0] wdata0,
    input  logic            req1,
    input  logic            we1,
    input  logic [AW-1:0]   addr1,
    input  logic [BITS-1:0] wdata1,
    output logic            ack0,
    output logic            ack1,
    output logic [BITS-1:0] rdata0,
    output logic [BITS-1:0] rdata1,
    output logic [AW-1:0]   mem_endr,
    output logic            mem_We,
    output logic [BITS-1:0] mem_din,
    input  logic [BITS-1:0] mem_dout
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_last_gnt;
    logic            r_ack0;
    logic            r_ack1;
    logic [BITS-1:0] r_rdata0;
    logic [BITS-1:0] r_rdata1;
    logic [AW-1:0]   r_endr;
    logic [BITS-1:0] r_din;

    logic [1:0]      w_gnt;
    logic            w_access;
    logic            w_win;
    logic            w_we;
    logic [AW-1:0]   w_endr;
    logic [BITS-1:0] w_din;

    arb2_select u_arb2_select (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (r_last_gnt),
        .gnt      (w_gnt)
    );

    // Next-state logic; an access happens only in IDLE with a winner
    always_comb begin
        w_state_nxt = r_state;
        w_access    = 1'b0;
        w_win       = PORT_CORE;
        case (r_state)
            ST_IDLE: begin
                if (|w_gnt) begin
                    w_access    = 1'b1;
                    w_win       = gnt_to_port(w_gnt);
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Memory-side mux; address and data hold their last driven values
    always_comb begin
        w_endr = r_endr;
        w_din  = r_din;
        w_we   = 1'b0;
        if (w_access) begin
            if (w_win == PORT_LOADER) begin
                w_endr = addr1;
                w_din  = wdata1;
                w_we   = we1;
            end else begin
                w_endr = addr0;
                w_din  = wdata0;
                w_we   = we0;
            end
        end
    end

    // Reset blocks any write and parks the memory inputs at zero
    assign mem_We   = w_we & ~rst;
    assign mem_endr = rst ? '0 : w_endr;
    assign mem_din  = rst ? '0 : w_din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_last_gnt <= LAST_GNT_RST;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
            r_endr     <= '0;
            r_din      <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack0  <= w_access && (w_win == PORT_CORE);
            r_ack1  <= w_access && (w_win == PORT_LOADER);
            if (w_access) begin
                r_last_gnt <= w_win;
                r_endr     <= w_endr;
                r_din      <= w_din;
                if (!w_we) begin
                    if (w_win == PORT_LOADER) begin
                        r_rdata1 <= mem_dout;
                    end else begin
                        r_rdata0 <= mem_dout;
                    end
                end
            end
        end
    end

    assign ack0   = r_ack0;
    assign ack1   = r_ack1;
    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter with a behavioural memory model.
module tb_data_mem_arbiter;

    localparam int unsigned BITS = 64;
    localparam int unsigned AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0, we0, req1, we1;
    logic [AW-1:0]   addr0, addr1;
    logic [BITS-1:0] wdata0, wdata1;
    logic            ack0, ack1;
    logic [BITS-1:0] rdata0, rdata1;
    logic [AW-1:0]   mem_endr;
    logic            mem_We;
    logic [BITS-1:0] mem_din;
    logic [BITS-1:0] mem_dout;
    logic            preload;

    logic [BITS-1:0] mem [32];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.BITS(BITS), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .we0      (we0),
        .addr0    (addr0),
        .wdata0   (wdata0),
        .req1     (req1),
        .we1      (we1),
        .addr1    (addr1),
        .wdata1   (wdata1),
        .ack0     (ack0),
        .ack1     (ack1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .mem_endr (mem_endr),
        .mem_We   (mem_We),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 32; k++) mem[k] <= 64'(k * 3);
            mem[3] <= 64'd2978;
            mem[5] <= 64'd55;
            mem[7] <= 64'h1111;
        end else if (mem_We) begin
            mem[mem_endr] <= mem_din;
        end
    end
    assign mem_dout = mem[mem_endr];

    typedef struct {
        logic            req0;
        logic            we0;
        logic [AW-1:0]   addr0;
        logic [BITS-1:0] wdata0;
        logic            req1;
        logic            we1;
        logic [AW-1:0]   addr1;
        logic [BITS-1:0] wdata1;
        logic            e_ack0;
        logic            e_ack1;
        logic            e_we;
        logic [AW-1:0]   e_endr;
        logic [BITS-1:0] e_din;
        logic [BITS-1:0] e_rd0;
        logic [BITS-1:0] e_rd1;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0,
                         input logic [BITS-1:0] d0, input logic r1, input logic w1,
                         input logic [AW-1:0] a1, input logic [BITS-1:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    logic e0, e1;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 5'd0, 64'd0,      1'b0, 1'b0, 5'd0, 64'd0,      1'b0, 1'b0, 1'b0, 5'd0, 64'd0,      64'd0,      64'd0};
        vecs[1] = '{1'b1, 1'b0, 5'd3, 64'd0,      1'b0, 1'b0, 5'd0, 64'd0,      1'b0, 1'b0, 1'b0, 5'd3, 64'd0,      64'd0,      64'd0};
        vecs[2] = '{1'b0, 1'b0, 5'd0, 64'd0,      1'b0, 1'b0, 5'd0, 64'd0,      1'b1, 1'b0, 1'b0, 5'd3, 64'd0,      64'd2978,   64'd0};
        vecs[3] = '{1'b0, 1'b0, 5'd0, 64'd0,      1'b0, 1'b0, 5'd0, 64'd0,      1'b0, 1'b0, 1'b0, 5'd3, 64'd0,      64'd2978,   64'd0};
        vecs[4] = '{1'b0, 1'b0, 5'd0, 64'd0,      1'b1, 1'b1, 5'd7, 64'hDEAD,   1'b0, 1'b0, 1'b1, 5'd7, 64'hDEAD,   64'd2978,   64'd0};
        vecs[5] = '{1'b0, 1'b0, 5'd0, 64'd0,      1'b0, 1'b0, 5'd0, 64'd0,      1'b0, 1'b1, 1'b0, 5'd7, 64'hDEAD,   64'd2978,   64'd0};
        vecs[6] = '{1'b1, 1'b0, 5'd7, 64'd0,      1'b0, 1'b0, 5'd0, 64'd0,      1'b0, 1'b0, 1'b0, 5'd7, 64'd0,      64'd2978,   64'd0};
        vecs[7] = '{1'b0, 1'b0, 5'd0, 64'd0,      1'b0, 1'b0, 5'd0, 64'd0,      1'b1, 1'b0, 1'b0, 5'd7, 64'd0,      64'hDEAD,   64'd0};
        vecs[8] = '{1'b0, 1'b0, 5'd0, 64'd0,      1'b1, 1'b0, 5'd5, 64'd0,      1'b0, 1'b0, 1'b0, 5'd5, 64'd0,      64'hDEAD,   64'd0};
        vecs[9] = '{1'b0, 1'b0, 5'd0, 64'd0,      1'b0, 1'b0, 5'd0, 64'd0,      1'b0, 1'b1, 1'b0, 5'd5, 64'd0,      64'hDEAD,   64'd55};

        rst = 1'b1;
        preload = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 5'd0, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        preload = 1'b0;
        check("rst ack0",   64'(ack0),     64'd0);
        check("rst ack1",   64'(ack1),     64'd0);
        check("rst rdata0", rdata0,        64'd0);
        check("rst rdata1", rdata1,        64'd0);
        check("rst we",     64'(mem_We),   64'd0);
        check("rst endr",   64'(mem_endr), 64'd0);
        check("rst din",    mem_din,       64'd0);
        rst = 1'b0;

        // Single reads and writes, one cycle per vector
        for (int i = 0; i < 10; i++) begin
            tick();
            drive(vecs[i].req0, vecs[i].we0, vecs[i].addr0, vecs[i].wdata0,
                  vecs[i].req1, vecs[i].we1, vecs[i].addr1, vecs[i].wdata1);
            #1;
            check($sformatf("v%0d ack0", i),   64'(ack0),     64'(vecs[i].e_ack0));
            check($sformatf("v%0d ack1", i),   64'(ack1),     64'(vecs[i].e_ack1));
            check($sformatf("v%0d we", i),     64'(mem_We),   64'(vecs[i].e_we));
            check($sformatf("v%0d endr", i),   64'(mem_endr), 64'(vecs[i].e_endr));
            check($sformatf("v%0d din", i),    mem_din,       vecs[i].e_din);
            check($sformatf("v%0d rdata0", i), rdata0,        vecs[i].e_rd0);
            check($sformatf("v%0d rdata1", i), rdata1,        vecs[i].e_rd1);
        end

        // Continuous contention; port 1 won last, so port 0 goes first
        for (int i = 0; i < 8; i++) begin
            tick();
            drive(1'b1, 1'b0, 5'd3, 64'd0, 1'b1, 1'b0, 5'd5, 64'd0);
            #1;
            e0 = 1'b0;
            e1 = 1'b0;
            if (i % 2 == 1) begin
`ifdef DATA_MEM_ARB_RR_EN
                e0 = (i % 4 == 1);
                e1 = (i % 4 == 3);
`else
                e0 = 1'b1;
`endif
            end
            check($sformatf("cont%0d ack0", i), 64'(ack0), 64'(e0));
            check($sformatf("cont%0d ack1", i), 64'(ack1), 64'(e1));
        end
        tick();
        drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 5'd0, 64'd0);
        #1;
        check("cont rdata0", rdata0, 64'd2978);
        check("cont rdata1", rdata1, 64'd55);

        // Request rising during the ack cycle is served in the next IDLE
        tick();
        drive(1'b1, 1'b0, 5'd3, 64'd0, 1'b0, 1'b0, 5'd0, 64'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 5'd5, 64'd0);
        #1;
        check("late ack0 pulse", 64'(ack0),     64'd1);
        check("late ack1 early", 64'(ack1),     64'd0);
        check("late endr held",  64'(mem_endr), 64'd3);
        tick();
        check("late ack0 drop",  64'(ack0),     64'd0);
        check("late ack1 wait",  64'(ack1),     64'd0);
        check("late endr",       64'(mem_endr), 64'd5);
        tick();
        drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 5'd0, 64'd0);
        #1;
        check("late ack1",       64'(ack1),     64'd1);
        check("late rdata1",     rdata1,        64'd55);

        // Reset asserted in an ack cycle clears outputs immediately
        tick();
        drive(1'b1, 1'b0, 5'd7, 64'd0, 1'b0, 1'b0, 5'd0, 64'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 5'd0, 64'd0);
        #1;
        check("pre-rst ack0",   64'(ack0), 64'd1);
        check("pre-rst rdata0", rdata0,    64'hDEAD);
        rst = 1'b1;
        #1;
        check("mid-rst ack0",   64'(ack0),     64'd0);
        check("mid-rst rdata0", rdata0,        64'd0);
        check("mid-rst rdata1", rdata1,        64'd0);
        check("mid-rst we",     64'(mem_We),   64'd0);
        check("mid-rst endr",   64'(mem_endr), 64'd0);
        check("mid-rst din",    mem_din,       64'd0);
        tick();
        rst = 1'b0;

        // Reset during a port 1 write access must block the write
        tick();
        drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 1'b1, 5'd7, 64'hBEEF);
        #1;
        check("wr-rst we before", 64'(mem_We), 64'd1);
        rst = 1'b1;
        #1;
        check("wr-rst we",   64'(mem_We),   64'd0);
        check("wr-rst endr", 64'(mem_endr), 64'd0);
        tick();
        check("wr-rst ack1", 64'(ack1), 64'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 5'd0, 64'd0);
        #1;
        check("wr-rst mem7", mem[7], 64'hDEAD);
        tick();
        check("wr-rst ack1 after", 64'(ack1), 64'd0);
        check("wr-rst mem7 after", mem[7],    64'hDEAD);

        // First contention after reset goes to port 0
        drive(1'b1, 1'b0, 5'd3, 64'd0, 1'b1, 1'b0, 5'd5, 64'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 5'd0, 64'd0);
        #1;
        check("post-rst ack0",   64'(ack0), 64'd1);
        check("post-rst ack1",   64'(ack1), 64'd0);
        check("post-rst rdata0", rdata0,    64'd2978);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
